// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi: seconds/minutes/hours time-of-day counter with a
// clock-to-seconds prescaler, synchronous time preset, NUM_ALARMS
// programmable alarm slots and a ringing/snooze/acknowledge state machine.
//
// Ports:
//   clk_i, reset_ni             system clock (rising edge), async active-low reset
//   load_i, load_*_i            synchronous time preset (out-of-range fields load 0)
//   alarm_wr_i, alarm_idx_i,
//   alarm_wr_en_i, alarm_wr_*_i slot write: enable + hh:mm:ss of slot alarm_idx_i
//   ack_i, snooze_i             user acknowledge / snooze buttons
//   hours_o, minutes_o,
//   seconds_o                   current time
//   tick_o                      one-cycle pulse per second tick
//   alarm_o                     high while ringing
//   alarm_hit_o                 sticky per-slot match flags
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | not ringing, waiting for a slot match
// RINGING  | alarm_o high; optional auto-stop after RING_TICKS
// SNOOZE   | silent, counting down SNOOZE_TICKS before re-ring
module alarm_clock_multi #(
  parameter int SEC_MOD      = 60,
  parameter int MIN_MOD      = 60,
  parameter int HR_MOD       = 24,
  parameter int SEC_W        = 6,
  parameter int MIN_W        = 6,
  parameter int HR_W         = 5,
  parameter int TICK_DIV     = 1,
  parameter int NUM_ALARMS   = 2,
  parameter int SNOOZE_TICKS = 5,
  parameter int RING_TICKS   = 0,
  localparam int IDX_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  load_i,
  input  logic [HR_W-1:0]       load_hours_i,
  input  logic [MIN_W-1:0]      load_minutes_i,
  input  logic [SEC_W-1:0]      load_seconds_i,
  input  logic                  alarm_wr_i,
  input  logic [IDX_W-1:0]      alarm_idx_i,
  input  logic                  alarm_wr_en_i,
  input  logic [HR_W-1:0]       alarm_wr_hours_i,
  input  logic [MIN_W-1:0]      alarm_wr_minutes_i,
  input  logic [SEC_W-1:0]      alarm_wr_seconds_i,
  input  logic                  ack_i,
  input  logic                  snooze_i,
  output logic [HR_W-1:0]       hours_o,
  output logic [MIN_W-1:0]      minutes_o,
  output logic [SEC_W-1:0]      seconds_o,
  output logic                  tick_o,
  output logic                  alarm_o,
  output logic [NUM_ALARMS-1:0] alarm_hit_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SNOOZE_TICKS + 1);
  localparam int RW = (RING_TICKS > 1) ? $clog2(RING_TICKS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RINGING, ST_SNOOZE} state_e;

  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_q, tick_d;
  logic [SEC_W-1:0] sec_q, sec_d, sec_n;
  logic [MIN_W-1:0] min_q, min_d, min_n;
  logic [HR_W-1:0]  hr_q, hr_d, hr_n;
  logic             wrap, adv;

  logic [NUM_ALARMS-1:0]            slot_en_q;
  logic [NUM_ALARMS-1:0][HR_W-1:0]  slot_hr_q;
  logic [NUM_ALARMS-1:0][MIN_W-1:0] slot_min_q;
  logic [NUM_ALARMS-1:0][SEC_W-1:0] slot_sec_q;
  logic [NUM_ALARMS-1:0]            match;

  state_e                state_q, state_d;
  logic [NUM_ALARMS-1:0] hit_q, hit_d;
  logic [RW-1:0]         ring_q, ring_d;
  logic [SW-1:0]         snz_q, snz_d;

  // Incremented time; only committed on a tick, but also used for matching
  // so the alarm rises on the same edge the display shows the alarm time.
  always_comb begin
    wrap  = (pre_q == PW'(TICK_DIV - 1));
    adv   = wrap && !load_i;
    sec_n = sec_q + 1'b1;
    min_n = min_q;
    hr_n  = hr_q;
    if (sec_q == SEC_W'(SEC_MOD - 1)) begin
      sec_n = '0;
      min_n = min_q + 1'b1;
      if (min_q == MIN_W'(MIN_MOD - 1)) begin
        min_n = '0;
        hr_n  = (hr_q == HR_W'(HR_MOD - 1)) ? '0 : hr_q + 1'b1;
      end
    end
  end

  always_comb begin
    pre_d  = wrap ? '0 : pre_q + 1'b1;
    tick_d = wrap;
    sec_d  = sec_q;
    min_d  = min_q;
    hr_d   = hr_q;
    if (load_i) begin
      pre_d  = '0;
      tick_d = 1'b0;
      sec_d  = (int'(load_seconds_i) >= SEC_MOD) ? '0 : load_seconds_i;
      min_d  = (int'(load_minutes_i) >= MIN_MOD) ? '0 : load_minutes_i;
      hr_d   = (int'(load_hours_i)   >= HR_MOD)  ? '0 : load_hours_i;
    end else if (wrap) begin
      sec_d = sec_n;
      min_d = min_n;
      hr_d  = hr_n;
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match[i] = adv && slot_en_q[i] && (slot_hr_q[i] == hr_n) &&
                 (slot_min_q[i] == min_n) && (slot_sec_q[i] == sec_n);
    end
  end

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ack_i) hit_d = '0;
        if (|match) begin
          state_d = ST_RINGING;
          ring_d  = '0;
        end
      end
      ST_RINGING: begin
        if (ack_i) begin
          state_d = ST_IDLE;
          hit_d   = '0;
        end else if (|match) begin
          ring_d = '0;
        end else if (snooze_i) begin
          state_d = ST_SNOOZE;
          snz_d   = SW'(SNOOZE_TICKS);
        end else if (RING_TICKS > 0 && adv) begin
          if (int'(ring_q) == RING_TICKS - 1) state_d = ST_IDLE;
          else                                ring_d  = ring_q + 1'b1;
        end
      end
      ST_SNOOZE: begin
        if (ack_i) begin
          state_d = ST_IDLE;
          hit_d   = '0;
        end else if (|match) begin
          state_d = ST_RINGING;
          ring_d  = '0;
        end else if (adv) begin
          if (snz_q == SW'(1)) begin
            state_d = ST_RINGING;
            ring_d  = '0;
          end
          snz_d = snz_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A match is recorded even when a same-cycle ack clears the flags.
    hit_d = hit_d | match;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      state_q <= ST_IDLE;
      hit_q   <= '0;
      ring_q  <= '0;
      snz_q   <= '0;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      state_q <= state_d;
      hit_q   <= hit_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      slot_en_q  <= '0;
      slot_hr_q  <= '0;
      slot_min_q <= '0;
      slot_sec_q <= '0;
    end else if (alarm_wr_i && (int'(alarm_idx_i) < NUM_ALARMS)) begin
      slot_en_q[alarm_idx_i]  <= alarm_wr_en_i;
      slot_hr_q[alarm_idx_i]  <= alarm_wr_hours_i;
      slot_min_q[alarm_idx_i] <= alarm_wr_minutes_i;
      slot_sec_q[alarm_idx_i] <= alarm_wr_seconds_i;
    end
  end

  assign hours_o     = hr_q;
  assign minutes_o   = min_q;
  assign seconds_o   = sec_q;
  assign tick_o      = tick_q;
  assign alarm_o     = (state_q == ST_RINGING);
  assign alarm_hit_o = hit_q;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed bench for alarm_clock_multi with TICK_DIV=4, two slots,
// SNOOZE_TICKS=5 and RING_TICKS=3. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_alarm_clock_multi;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [4:0] load_h;
  logic [5:0] load_m, load_s;
  logic       alarm_wr;
  logic       alarm_idx;
  logic       wr_en;
  logic [4:0] wr_h;
  logic [5:0] wr_m, wr_s;
  logic       ack, snooze;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic       tick, alarm;
  logic [1:0] alarm_hit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alarm_clock_multi #(
    .TICK_DIV(4), .NUM_ALARMS(2), .SNOOZE_TICKS(5), .RING_TICKS(3)
  ) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .load_i(load), .load_hours_i(load_h), .load_minutes_i(load_m), .load_seconds_i(load_s),
    .alarm_wr_i(alarm_wr), .alarm_idx_i(alarm_idx), .alarm_wr_en_i(wr_en),
    .alarm_wr_hours_i(wr_h), .alarm_wr_minutes_i(wr_m), .alarm_wr_seconds_i(wr_s),
    .ack_i(ack), .snooze_i(snooze),
    .hours_o(hours), .minutes_o(minutes), .seconds_o(seconds),
    .tick_o(tick), .alarm_o(alarm), .alarm_hit_o(alarm_hit)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hms(input int h, input int m, input int s);
    return {15'd0, 5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [31:0] now();
    return {15'd0, hours, minutes, seconds};
  endfunction

  task automatic load_time(input int h, input int m, input int s);
    load = 1'b1; load_h = 5'(h); load_m = 6'(m); load_s = 6'(s);
    step(1);
    load = 1'b0;
  endtask

  task automatic write_slot(input int idx, input logic en, input int h, input int m, input int s);
    alarm_wr = 1'b1; alarm_idx = idx[0]; wr_en = en;
    wr_h = 5'(h); wr_m = 6'(m); wr_s = 6'(s);
    step(1);
    alarm_wr = 1'b0;
  endtask

  task automatic pulse_ack_snooze(input logic a, input logic s);
    ack = a; snooze = s;
    step(1);
    ack = 1'b0; snooze = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; load = 1'b0; load_h = '0; load_m = '0; load_s = '0;
    alarm_wr = 1'b0; alarm_idx = 1'b0; wr_en = 1'b0; wr_h = '0; wr_m = '0; wr_s = '0;
    ack = 1'b0; snooze = 1'b0;

    // reset values and prescaler
    step(2);
    chk("rst_time", now(), hms(0, 0, 0));
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_hit", 32'(alarm_hit), 32'd0);
    reset_n = 1'b1;
    step(3);
    chk("pre_tick3", 32'(tick), 32'd0);
    chk("pre_sec3", now(), hms(0, 0, 0));
    step(1);
    chk("pre_tick4", 32'(tick), 32'd1);
    chk("pre_sec4", now(), hms(0, 0, 1));
    step(1);
    chk("pre_tick5", 32'(tick), 32'd0);

    // rollover and preset
    load_time(23, 59, 58);
    chk("load_time", now(), hms(23, 59, 58));
    chk("load_tick", 32'(tick), 32'd0);
    step(4);
    chk("roll_59", now(), hms(23, 59, 59));
    chk("roll_tick", 32'(tick), 32'd1);
    step(4);
    chk("roll_wrap", now(), hms(0, 0, 0));
    load_time(24, 60, 61);
    chk("load_clamp", now(), hms(0, 0, 0));
    step(3);
    load_time(0, 0, 10);
    chk("load_over_tick", now(), hms(0, 0, 10));
    chk("load_over_tick_t", 32'(tick), 32'd0);
    step(4);
    chk("after_load_tick", now(), hms(0, 0, 11));

    // two slots, one disabled
    write_slot(0, 1'b1, 0, 0, 3);
    write_slot(1, 1'b0, 0, 0, 3);
    load_time(0, 0, 0);
    step(8);
    chk("s3_pre_alarm", 32'(alarm), 32'd0);
    step(4);
    chk("s3_time", now(), hms(0, 0, 3));
    chk("s3_alarm", 32'(alarm), 32'd1);
    chk("s3_hit", 32'(alarm_hit), 32'b01);
    pulse_ack_snooze(1'b1, 1'b0);
    chk("s3_ack_alarm", 32'(alarm), 32'd0);
    chk("s3_ack_hit", 32'(alarm_hit), 32'd0);

    // snooze and re-ring
    write_slot(0, 1'b1, 0, 1, 0);
    load_time(0, 0, 58);
    step(4);
    chk("s4_pre", 32'(alarm), 32'd0);
    step(4);
    chk("s4_ring", 32'(alarm), 32'd1);
    pulse_ack_snooze(1'b0, 1'b1);
    chk("s4_snoozed", 32'(alarm), 32'd0);
    chk("s4_snz_hit", 32'(alarm_hit), 32'b01);
    step(18);
    chk("s4_t4_time", now(), hms(0, 1, 4));
    chk("s4_t4_alarm", 32'(alarm), 32'd0);
    step(1);
    chk("s4_t5_time", now(), hms(0, 1, 5));
    chk("s4_rering", 32'(alarm), 32'd1);
    pulse_ack_snooze(1'b1, 1'b1);
    chk("s4_acksnz_alarm", 32'(alarm), 32'd0);
    chk("s4_acksnz_hit", 32'(alarm_hit), 32'd0);
    step(24);
    chk("s4_stays_idle", 32'(alarm), 32'd0);

    // auto-stop, second slot while ringing
    write_slot(0, 1'b1, 0, 2, 2);
    write_slot(1, 1'b1, 0, 2, 3);
    load_time(0, 2, 0);
    step(8);
    chk("s5_ring", 32'(alarm), 32'd1);
    chk("s5_hit0", 32'(alarm_hit), 32'b01);
    step(4);
    chk("s5_second_alarm", 32'(alarm), 32'd1);
    chk("s5_hit_both", 32'(alarm_hit), 32'b11);
    step(8);
    chk("s5_still_ring", 32'(alarm), 32'd1);
    step(4);
    chk("s5_autostop", 32'(alarm), 32'd0);
    chk("s5_hit_kept", 32'(alarm_hit), 32'b11);
    pulse_ack_snooze(1'b1, 1'b0);
    chk("s5_idle_ack_hit", 32'(alarm_hit), 32'd0);

    // async reset mid-snooze
    load_time(0, 2, 1);
    step(4);
    chk("s6_ring", 32'(alarm), 32'd1);
    pulse_ack_snooze(1'b0, 1'b1);
    chk("s6_snz_hit", 32'(alarm_hit), 32'b01);
    #2 reset_n = 1'b0;
    #1;
    chk("s6_rst_alarm", 32'(alarm), 32'd0);
    chk("s6_rst_hit", 32'(alarm_hit), 32'd0);
    chk("s6_rst_time", now(), hms(0, 0, 0));
    #1 reset_n = 1'b1;
    step(1);
    load_time(0, 2, 1);
    step(4);
    chk("s6_slots_off_time", now(), hms(0, 2, 2));
    chk("s6_slots_off", 32'(alarm), 32'd0);
    step(24);
    chk("s6_no_rering", 32'(alarm), 32'd0);
    chk("s6_no_hit", 32'(alarm_hit), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_clock_multi.md
Name: alarm_clock_multi

Overview:
- Parametrised successor to the single-alarm seconds/minutes/hours counter block.
- Adds configurable moduli and widths, a clock-to-seconds prescaler and synchronous time preset.
- Adds NUM_ALARMS programmable alarm slots with per-slot enable, plus a ringing/snooze/acknowledge state machine.
- Sits between the top-level pin wrapper (clock, buttons) and the display/buzzer logic.

Parameters:
SEC_MOD, 60, seconds modulus (seconds count 0..SEC_MOD-1)
MIN_MOD, 60, minutes modulus
HR_MOD, 24, hours modulus
SEC_W, 6, seconds field width (2^SEC_W >= SEC_MOD)
MIN_W, 6, minutes field width
HR_W, 5, hours field width
TICK_DIV, 1, clk cycles per one-second tick (>=1)
NUM_ALARMS, 2, number of alarm slots (>=2); IDX_W = $clog2(NUM_ALARMS)
SNOOZE_TICKS, 5, ticks spent in SNOOZE before re-ringing (>=1)
RING_TICKS, 0, ticks of unacknowledged ringing before auto-stop; 0 = ring forever

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
load  in  1  synchronous time preset strobe
load_hours  in  HR_W  preset hours
load_minutes  in  MIN_W  preset minutes
load_seconds  in  SEC_W  preset seconds
alarm_wr  in  1  alarm slot write strobe
alarm_idx  in  IDX_W  slot to write
alarm_wr_en  in  1  enable bit written to slot
alarm_wr_hours  in  HR_W  slot hours
alarm_wr_minutes  in  MIN_W  slot minutes
alarm_wr_seconds  in  SEC_W  slot seconds
ack  in  1  acknowledge/stop alarm
snooze  in  1  snooze request
hours  out  HR_W  current hours
minutes  out  MIN_W  current minutes
seconds  out  SEC_W  current seconds
tick  out  1  one-cycle pulse per second tick
alarm  out  1  high while ringing
alarm_hit  out  NUM_ALARMS  sticky per-slot match flags

Behaviour:
- Reset (reset=0, async): time 0:0:0, prescaler 0, tick 0, alarm 0, alarm_hit 0, all slots 0:0:0 and disabled, FSM IDLE, snooze/ring counters 0.
- Prescaler: counts 0..TICK_DIV-1. tick is registered high in the cycle the count wraps. With TICK_DIV=1, tick is high every cycle after reset.
- Time advance on tick:
  - seconds+1; at SEC_MOD-1 wraps to 0 and carries to minutes.
  - minutes wraps at MIN_MOD-1 and carries to hours.
  - hours wraps at HR_MOD-1 to 0.
  - Full rollover HR_MOD-1:MIN_MOD-1:SEC_MOD-1 -> 0:0:0.
- load:
  - Highest priority; overrides a same-cycle tick.
  - Each field >= its modulus loads as 0.
  - Prescaler cleared; tick stays low that cycle.
  - No alarm match is evaluated on a load cycle.
- Match evaluation:
  - Only on tick cycles, against the next time value, so alarm rises on the same edge the display shows the matching time.
  - Slot i matches if enabled and all three fields are equal.
  - Every matching slot sets alarm_hit[i].
- Slot write:
  - alarm_wr writes all fields plus the enable of slot alarm_idx on the next edge.
  - alarm_idx >= NUM_ALARMS: write ignored.
  - A write never alters the FSM state or alarm_hit.
  - When a write and a match on the same slot occur in the same cycle, the match uses the old slot contents.
- FSM states IDLE, RINGING, SNOOZE; alarm = (state==RINGING).
  - IDLE -> RINGING on any match; ring counter cleared.
  - RINGING + ack -> IDLE; alarm_hit cleared.
  - RINGING + snooze (no ack) -> SNOOZE; snooze counter loaded with SNOOZE_TICKS.
  - RINGING with RING_TICKS>0: counts ticks; on the RING_TICKS-th tick -> IDLE. alarm_hit is retained.
  - RINGING + new match: stays RINGING; new hit OR'd in; ring counter cleared.
  - SNOOZE: decrements on tick; reaching 0 -> RINGING.
  - SNOOZE + ack -> IDLE with alarm_hit cleared.
  - SNOOZE + match -> RINGING immediately.
  - ack and snooze together: ack wins.
  - ack in IDLE clears alarm_hit; snooze in IDLE is ignored.
  - A same-cycle match and ack: ack wins, but the matching slot's alarm_hit bit is set after the clear.
- Reset asserted mid-ring or mid-snooze returns everything to reset values immediately.

Test Plan:
1. Reset release, TICK_DIV=4: tick high every 4th cycle; seconds 0->1 after 4 cycles; outputs all 0 during reset.
2. Rollover: load 23:59:58, 2 ticks -> 23:59:59 then 0:0:0; load 24:60:61 -> 0:0:0; load in a tick cycle suppresses the increment.
3. Two slots: slot0=0:0:3 enabled, slot1=0:0:3 disabled -> at 0:0:3 alarm=1 on the same edge, alarm_hit=2'b01; ack -> alarm=0, alarm_hit=0.
4. Snooze, SNOOZE_TICKS=5: ring at 0:1:0, snooze -> alarm=0; re-rings exactly 5 ticks later at 0:1:5; ack+snooze same cycle -> IDLE.
5. Auto-stop, RING_TICKS=3: no ack -> alarm drops after 3rd tick, alarm_hit stays set; second slot matching while ringing keeps alarm=1 and sets both hit bits.
6. Async reset pulsed mid-SNOOZE, between clock edges -> alarm, alarm_hit and time clear immediately; slots disabled; no ring after release.
